gray_tracker: RTL

GRAY_TRACKER -- requirements
Module: gray_tracker

---
 rtl/gray_tracker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gray_tracker.sv
// Tracks a 3-bit reflected Gray code input, reporting its binary value, step direction,
// wrap pulses, a floored/saturating net wrap count and a sticky illegal-step flag.
module gray_tracker #(
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [2:0]        GrayIn,
  input  logic              Clear,
  output logic [2:0]        Output,
  output logic              Dir,
  output logic              Overflow,
  output logic              Underflow,
  output logic [WRAP_W-1:0] WrapCnt,
  output logic              Error
);

  typedef enum logic [1:0] {IDLE, TRACK, ERR} state_t;

  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  state_t            state_q, state_d;
  logic [2:0]        out_q, out_d;
  logic              dir_q, dir_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              err_q, err_d;
  logic [2:0]        bin;
  logic [2:0]        step;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  assign bin  = gray2bin(GrayIn);
  // Modulo-8 distance from the current position; only +1 and -1 are legal moves.
  assign step = bin - out_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    dir_d   = dir_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wrap_d  = wrap_q;
    err_d   = err_q;
    if (Clear) begin
      state_d = IDLE;
      out_d   = 3'd0;
      dir_d   = 1'b1;
      wrap_d  = '0;
      err_d   = 1'b0;
    end else if (En) begin
      case (state_q)
        IDLE: begin
          out_d   = bin;
          state_d = TRACK;
        end
        TRACK: begin
          case (step)
            3'd0: ;
            3'd1: begin
              out_d = bin;
              dir_d = 1'b1;
              if (out_q == 3'd7) begin
                ovf_d = 1'b1;
                if (wrap_q != WRAP_MAX) wrap_d = wrap_q + WRAP_W'(1);
              end
            end
            3'd7: begin
              out_d = bin;
              dir_d = 1'b0;
              if (out_q == 3'd0) begin
                unf_d = 1'b1;
                if (wrap_q != '0) wrap_d = wrap_q - WRAP_W'(1);
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      out_q   <= 3'd0;
      dir_q   <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      wrap_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign Output    = out_q;
  assign Dir       = dir_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign WrapCnt   = wrap_q;
  assign Error     = err_q;

endmodule
